// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file port: ALU results win, load returns queue in a FIFO.
// Optional macro WB_BYPASS_EN lets a return go straight to the port when the FIFO is empty and the ALU is idle.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_wn,
    input  logic [DATA_W-1:0]             alu_d,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_W-1:0]             mem_wn,
    input  logic [DATA_W-1:0]             mem_d,
    output logic                          wb_we,
    output logic [ADDR_W-1:0]             wb_wn,
    output logic [DATA_W-1:0]             wb_d,
    output logic                          wb_src,
    output logic [(1<<ADDR_W)-1:0]        pend_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          hazard
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] wn;
        logic [DATA_W-1:0] d;
    } wb_entry_t;

    wb_entry_t [FIFO_DEPTH-1:0] fifo_q, fifo_d;
    logic [FIFO_DEPTH-1:0]      ent_vld_q, ent_vld_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic                       we_q, we_d;
    logic [ADDR_W-1:0]          wn_q, wn_d;
    logic [DATA_W-1:0]          dat_q, dat_d;
    logic                       src_q, src_d;
    logic                       haz_q, haz_d;

    logic                       fifo_full, fifo_empty;
    logic                       bypass, push, pop;
    wb_entry_t                  head;

    // Ready depends only on occupancy, so it never sees a same-cycle pop.
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign mem_ready  = !fifo_full;
    assign fifo_count = cnt_q;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (ent_vld_q[i]) pend_mask[fifo_q[i].wn] = 1'b1;
    end

    always_comb begin
`ifdef WB_BYPASS_EN
        bypass = fifo_empty && !alu_valid && mem_valid;
`else
        bypass = 1'b0;
`endif
        pop  = !alu_valid && !fifo_empty;
        push = mem_valid && !fifo_full && !bypass;
        head = fifo_q[rd_ptr_q];
    end

    always_comb begin
        we_d  = 1'b0;
        wn_d  = wn_q;
        dat_d = dat_q;
        src_d = src_q;
        haz_d = alu_valid && pend_mask[alu_wn];
        if (alu_valid) begin
            we_d  = 1'b1;
            wn_d  = alu_wn;
            dat_d = alu_d;
            src_d = 1'b0;
        end else if (pop) begin
            we_d  = 1'b1;
            wn_d  = head.wn;
            dat_d = head.d;
            src_d = 1'b1;
        end else if (bypass) begin
            we_d  = 1'b1;
            wn_d  = mem_wn;
            dat_d = mem_d;
            src_d = 1'b1;
        end
    end

    // Push and pop never share a slot: pop needs non-empty, push needs non-full.
    always_comb begin
        fifo_d    = fifo_q;
        ent_vld_d = ent_vld_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q].wn = mem_wn;
            fifo_d[wr_ptr_q].d  = mem_d;
            ent_vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_q    <= '0;
            ent_vld_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            wn_q      <= '0;
            dat_q     <= '0;
            src_q     <= 1'b0;
            haz_q     <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            ent_vld_q <= ent_vld_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            wn_q      <= wn_d;
            dat_q     <= dat_d;
            src_q     <= src_d;
            haz_q     <= haz_d;
        end
    end

    assign wb_we  = we_q;
    assign wb_wn  = wn_q;
    assign wb_d   = dat_q;
    assign wb_src = src_q;
    assign hazard = haz_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table plus hand sequences and a queue-model random run for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, mem_ready;
    logic [3:0]  alu_wn, mem_wn, wb_wn;
    logic [15:0] alu_d, mem_d, wb_d, pend_mask;
    logic        wb_we, wb_src, hazard;
    logic [2:0]  fifo_count;

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_wn(alu_wn), .alu_d(alu_d),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wn(mem_wn), .mem_d(mem_d),
        .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d), .wb_src(wb_src),
        .pend_mask(pend_mask), .fifo_count(fifo_count), .hazard(hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;  logic [3:0] awn; logic [15:0] ad;
        logic        mv;  logic [3:0] mwn; logic [15:0] md;
        logic        we;  logic [3:0] wn;  logic [15:0] d;  logic src;
        logic        rdy; logic [2:0] cnt; logic [15:0] pend; logic haz;
    } vec_t;

    typedef struct { logic [3:0] wn; logic [15:0] d; } ent_t;

    vec_t tbl [12];
    int   tot = 0;
    int   pass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [15:0] qmask(input ent_t q[$]);
        logic [15:0] m = '0;
        foreach (q[i]) m[q[i].wn] = 1'b1;
        return m;
    endfunction

    task automatic idle_in();
        alu_valid = 1'b0; alu_wn = '0; alu_d = '0;
        mem_valid = 1'b0; mem_wn = '0; mem_d = '0;
    endtask

    initial begin
        ent_t        got[$];
        ent_t        mq[$];
        ent_t        e;
        logic        acc, byp, exp_we, exp_src, exp_rdy, exp_haz;
        logic [3:0]  exp_wn;
        logic [15:0] exp_d, pre_mask;
        int          wlist[5];
        int          idx, pushes, n, wr_cnt;

        idle_in();
        rst_n = 1'b0;
        tick(); tick();
        chk("reset_state", {wb_we, wb_wn, wb_d, wb_src, hazard, mem_ready, fifo_count, pend_mask},
            {1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0});
        rst_n = 1'b1;

        // av awn ad mv mwn md | we wn d src rdy cnt pend haz
        tbl[0]  = '{1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000,1'b0, 1'b1,3'd0,16'h0000,1'b0};
        tbl[1]  = '{1'b1,4'h3,16'h1234, 1'b0,4'h0,16'h0000, 1'b1,4'h3,16'h1234,1'b0, 1'b1,3'd0,16'h0000,1'b0};
        tbl[2]  = '{1'b1,4'h1,16'h0011, 1'b1,4'h7,16'h7777, 1'b1,4'h1,16'h0011,1'b0, 1'b1,3'd1,16'h0080,1'b0};
        tbl[3]  = '{1'b1,4'h7,16'h00A7, 1'b1,4'h2,16'h2222, 1'b1,4'h7,16'h00A7,1'b0, 1'b1,3'd2,16'h0084,1'b1};
        tbl[4]  = '{1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b1,4'h7,16'h7777,1'b1, 1'b1,3'd1,16'h0004,1'b0};
        tbl[5]  = '{1'b1,4'h2,16'h00B2, 1'b0,4'h0,16'h0000, 1'b1,4'h2,16'h00B2,1'b0, 1'b1,3'd1,16'h0004,1'b1};
        tbl[6]  = '{1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b1,4'h2,16'h2222,1'b1, 1'b1,3'd0,16'h0000,1'b0};
        tbl[7]  = '{1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b0,4'h2,16'h2222,1'b0, 1'b1,3'd0,16'h0000,1'b0};
        tbl[8]  = '{1'b1,4'h9,16'h0909, 1'b1,4'hA,16'h0A0A, 1'b1,4'h9,16'h0909,1'b0, 1'b1,3'd1,16'h0400,1'b0};
        tbl[9]  = '{1'b0,4'h0,16'h0000, 1'b1,4'hB,16'h0B0B, 1'b1,4'hA,16'h0A0A,1'b1, 1'b1,3'd1,16'h0800,1'b0};
        tbl[10] = '{1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b1,4'hB,16'h0B0B,1'b1, 1'b1,3'd0,16'h0000,1'b0};
        tbl[11] = '{1'b0,4'h0,16'h0000, 1'b0,4'h0,16'h0000, 1'b0,4'hB,16'h0B0B,1'b0, 1'b1,3'd0,16'h0000,1'b0};

        for (int i = 0; i < 12; i++) begin
            alu_valid = tbl[i].av; alu_wn = tbl[i].awn; alu_d = tbl[i].ad;
            mem_valid = tbl[i].mv; mem_wn = tbl[i].mwn; mem_d = tbl[i].md;
            tick();
            chk($sformatf("vec%0d", i),
                {wb_we, wb_wn, wb_d, wb_we & wb_src, mem_ready, fifo_count, pend_mask, hazard},
                {tbl[i].we, tbl[i].wn, tbl[i].d, tbl[i].we & tbl[i].src, tbl[i].rdy, tbl[i].cnt,
                 tbl[i].pend, tbl[i].haz});
        end
        idle_in();

        // Load return latency with an empty FIFO and idle ALU
        mem_valid = 1'b1; mem_wn = 4'd5; mem_d = 16'hBEEF;
        tick();
        idle_in();
`ifdef WB_BYPASS_EN
        chk("mem_lat_c2", {wb_we, wb_wn, wb_d, wb_src, pend_mask}, {1'b1, 4'd5, 16'hBEEF, 1'b1, 16'h0000});
        tick();
        chk("mem_lat_c3", {wb_we, pend_mask, fifo_count}, {1'b0, 16'h0000, 3'd0});
`else
        chk("mem_lat_c2", {wb_we, pend_mask, fifo_count}, {1'b0, 16'h0020, 3'd1});
        tick();
        chk("mem_lat_c3", {wb_we, wb_wn, wb_d, wb_src, pend_mask}, {1'b1, 4'd5, 16'hBEEF, 1'b1, 16'h0000});
`endif
        tick();

        // Fill under sustained ALU traffic, then drain in arrival order
        wlist[0] = 1; wlist[1] = 2; wlist[2] = 3; wlist[3] = 4; wlist[4] = 6;
        idx = 0;
        alu_valid = 1'b1; alu_wn = 4'd0; alu_d = 16'h00AA;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            mem_valid = 1'b1; mem_wn = 4'(wlist[idx]); mem_d = 16'hC000 + 16'(wlist[idx]);
            acc = mem_ready;
            tick();
            if (acc) idx++;
        end
        mem_wn = 4'd6; mem_d = 16'hC006;
        tick();
        chk("full_hold", {mem_ready, fifo_count, pend_mask}, {1'b0, 3'd4, 16'h001E});
        alu_valid = 1'b0;
        got.delete();
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            acc = mem_valid && mem_ready;
            tick();
            if (acc) mem_valid = 1'b0;
            if (c == 0) chk("full_no_push", {wb_wn, fifo_count}, {4'd1, 3'd3});
            if (wb_we) got.push_back('{wb_wn, wb_d});
        end
        chk("drain_len", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("drain%0d", i), {got[i].wn, got[i].d},
                {4'(wlist[i]), 16'hC000 + 16'(wlist[i])});
        idle_in();
        tick();

        // Reset flushes queued loads, none is ever written
        alu_valid = 1'b1; alu_wn = 4'd0; alu_d = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_wn = 4'(8 + i); mem_d = 16'hD000 + 16'(i);
            tick();
        end
        chk("flush_fill", {fifo_count, pend_mask}, {3'd3, 16'h0700});
        idle_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("flush_reset", {fifo_count, pend_mask, wb_we, mem_ready}, {3'd0, 16'h0000, 1'b0, 1'b1});
        wr_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (wb_we) wr_cnt++;
        end
        chk("flush_no_write", 64'(wr_cnt), 64'd0);

        // Random traffic against a queue model
        mq.delete();
        pushes = 0;
        n = 0;
        while ((n < 20 || pushes < 2 * DEPTH + 1 || mq.size() > 0) && n < 300) begin
            if (n < 20 || pushes < 2 * DEPTH + 1) begin
                alu_valid = ($urandom_range(0, 2) == 0);
                alu_wn = 4'($urandom_range(0, 15)); alu_d = 16'($urandom);
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_wn = 4'($urandom_range(0, 15)); mem_d = 16'($urandom);
            end else idle_in();
            exp_rdy  = (mq.size() < DEPTH);
            pre_mask = qmask(mq);
            exp_haz  = alu_valid && pre_mask[alu_wn];
            chk("rand_ready", {63'd0, mem_ready}, {63'd0, exp_rdy});
`ifdef WB_BYPASS_EN
            byp = (mq.size() == 0) && !alu_valid && mem_valid;
`else
            byp = 1'b0;
`endif
            acc = mem_valid && exp_rdy;
            exp_we = 1'b1; exp_wn = '0; exp_d = '0; exp_src = 1'b0;
            if (alu_valid) begin
                exp_wn = alu_wn; exp_d = alu_d;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                exp_wn = e.wn; exp_d = e.d; exp_src = 1'b1;
            end else if (byp) begin
                exp_wn = mem_wn; exp_d = mem_d; exp_src = 1'b1;
            end else exp_we = 1'b0;
            if (acc && !byp) begin
                mq.push_back('{mem_wn, mem_d});
                pushes++;
            end
            tick();
            chk($sformatf("rand%0d", n),
                {wb_we, exp_we ? {wb_wn, wb_d, wb_src} : 21'd0, fifo_count, pend_mask, hazard},
                {exp_we, exp_we ? {exp_wn, exp_d, exp_src} : 21'd0, 3'(mq.size()), qmask(mq), exp_haz});
            n++;
        end
        chk("rand_wrap", {63'd0, pushes >= 2 * DEPTH + 1}, {63'd0, 1'b1});
        chk("rand_bound", {63'd0, n < 300}, {63'd0, 1'b1});

        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback stage directly upstream of the 16x16 register file write port. It merges two result sources into the single `d`/`wn`/`we` port: ALU results, which never stall, and memory load returns, which use a valid/ready handshake. Load returns that lose arbitration wait in a small FIFO. The block exports a pending-write mask so issue logic can detect RAW/WAW hazards against queued loads.

## Interface
- `DATA_W`, 16, data width; must match the register file.
- `ADDR_W`, 4, register index width (16 registers).
- `FIFO_DEPTH`, 4, load-return FIFO entries; a power of 2, minimum 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `alu_valid`  in  1  ALU result present this cycle; always accepted.
- `alu_wn`  in  ADDR_W  ALU destination register.
- `alu_d`  in  DATA_W  ALU result.
- `mem_valid`  in  1  load return offered.
- `mem_ready`  out  1  load return accepted when `mem_valid & mem_ready`.
- `mem_wn`  in  ADDR_W  load destination register.
- `mem_d`  in  DATA_W  load data.
- `wb_we`  out  1  write enable to the register file (`we`).
- `wb_wn`  out  ADDR_W  write index (`wn`).
- `wb_d`  out  DATA_W  write data (`d`).
- `wb_src`  out  1  0 = the current write came from the ALU, 1 = from memory.
- `pend_mask`  out  16  bit i set while any FIFO entry targets register i.
- `fifo_count`  out  log2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- `hazard`  out  1  one-cycle pulse: an ALU write was accepted whose `alu_wn` bit was set in `pend_mask`.

## Operation
- `wb_we`, `wb_wn`, `wb_d`, `wb_src`, and `hazard` are registered. `mem_ready`, `pend_mask`, and `fifo_count` are derived from registered state only; none depend combinationally on inputs.
- Priority each cycle:
  - If `alu_valid` is high, the ALU result is loaded into the output register.
  - Otherwise, if the FIFO is non-empty, the FIFO head is popped into the output register.
  - Otherwise, `wb_we` is 0. `wb_wn`/`wb_d` hold their previous values.
- A handshaked load return is pushed into the FIFO at the same edge, except in the bypass case (see Configuration).
- `mem_ready` = !full. When the FIFO is full, no push is accepted, even in a cycle where a pop occurs.
- The FIFO uses circular read/write pointers with wrap-around at `FIFO_DEPTH`. A simultaneous push and pop leaves `fifo_count` unchanged.
- `pend_mask` is the OR of one-hot(`wn`) over all valid FIFO entries. In the bypass case, a bypassed return never appears in the mask.
- Loads are written in arrival order. ALU writes are never reordered behind loads. Ordering is the issue stage's job via `pend_mask`; this block only flags violations on `hazard`.
- Reset: the FIFO is flushed and all queued entries are discarded. Pointers and `fifo_count` go to 0. `wb_we`, `wb_wn`, `wb_d`, `wb_src`, and `hazard` go to 0. `pend_mask` is 0 and `mem_ready` is 1 from the first cycle after reset.

## Timing
- ALU path: `alu_valid` at cycle N gives `wb_we`=1 at N+1, and the register file is written at the end of N+1.
- Memory path, without bypass: a return accepted at N becomes eligible at N+1. If the ALU is idle, `wb_we`=1 at N+2. Each ALU-valid cycle adds one cycle of delay.
- Sustained ALU traffic starves the FIFO indefinitely. That is the intended behaviour, and `mem_ready` back-pressures once the FIFO is full.
- Throughput: one write per cycle maximum.

## Configuration
- `WB_BYPASS_EN`:
  - Defined: when the FIFO is empty, `alu_valid` is 0, and `mem_valid` is 1, the return goes directly into the output register without a FIFO push. The memory path then has 1-cycle latency (`wb_we` at N+1).
  - Undefined: every accepted return passes through the FIFO, giving 2-cycle minimum latency.
- All other behaviour is identical with or without the macro.

## Test plan
- Reset, then `alu_valid`=1, `alu_wn`=3, `alu_d`=0x1234 at cycle 1 → cycle 2: `wb_we`=1, `wb_wn`=3, `wb_d`=0x1234, `wb_src`=0.
- FIFO empty, ALU idle, memory return (wn=5, d=0xBEEF) at cycle 1 → `wb_we`=1, `wb_wn`=5, `wb_d`=0xBEEF at cycle 2 with `WB_BYPASS_EN` defined, at cycle 3 without it; `pend_mask` stays 0 with bypass and equals 0x0020 for one cycle without.
- `alu_valid` held high while 5 returns (wn=1,2,3,4,6) are offered → 4 accepted, `mem_ready`=0 with `fifo_count`=4, `pend_mask`=0x001E; drop `alu_valid` → four writes in order 1,2,3,4, then wn=6 is accepted.
- With `pend_mask` bit 7 set (queued load to r7), ALU writes r7 → `hazard` pulses for one cycle, and the ALU write still occurs first.
- Fill the FIFO to 3 entries, assert `rst_n`=0 for one cycle → the next cycle has `fifo_count`=0, `pend_mask`=0, `wb_we`=0, `mem_ready`=1, and none of the flushed entries is ever written.
- 20 cycles of random ALU/memory traffic with a scoreboard model → write order and data match, pointer wrap-around is exercised at least twice, and no write is lost or duplicated.
